// File: rtl/m68k_bus_initiator_pkg.sv
// ============================================================================
//  Module      : m68k_bus_initiator_pkg
//  Description : Shared constants for the 68k-style bus initiator: FSM state
//                encoding, byte-enable codes and a byte-enable normaliser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package m68k_bus_initiator_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ADDR       = 3'd1;
    localparam logic [2:0] ST_STROBE     = 3'd2;
    localparam logic [2:0] ST_WAIT_DTACK = 3'd3;
    localparam logic [2:0] ST_LATCH      = 3'd4;
    localparam logic [2:0] ST_RELEASE    = 3'd5;

    // Byte-enable codes: bit 1 = upper byte (UDS_L), bit 0 = lower byte (LDS_L)
    localparam logic [1:0] BE_NONE  = 2'b00;
    localparam logic [1:0] BE_LOWER = 2'b01;
    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_BOTH  = 2'b11;

    // A request with no lanes enabled is treated as a full-word transfer
    function automatic logic [1:0] be_normalize(input logic [1:0] be);
        return (be == BE_NONE) ? BE_BOTH : be;
    endfunction

endpackage

`default_nettype wire

// File: rtl/m68k_bus_initiator.sv
// ============================================================================
//  Module      : m68k_bus_initiator
//  Description : Bus-master side of the 68k asynchronous AS_L/DS_L/DTACK_L
//                handshake. Runs one word/byte transfer per client request,
//                waits for DTACK, captures read data, releases the bus and
//                pulses Done_H. Optional bus-error timeout in WAIT_DTACK is
//                enabled by defining BUS_TIMEOUT_EN (adds TIMEOUT_CYCLES).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m68k_bus_initiator
    import m68k_bus_initiator_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 16
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              Clock,
    input  logic              Reset_H,
    // client side
    input  logic              Req_H,
    input  logic              ReqRW_H,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [1:0]        ReqByteEn,
    input  logic [DATA_W-1:0] ReqWrData,
    output logic              Busy_H,
    output logic              Done_H,
    output logic              Berr_H,
    output logic [DATA_W-1:0] RdData,
    // system bus side
    output logic [ADDR_W-1:0] AddressOut,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataOutEn_H,
    output logic              RW_L,
    output logic              AS_L,
    output logic              UDS_L,
    output logic              LDS_L,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              DtackIn_L
);

    logic [2:0]        state_q, state_d;
    logic              dtack_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        be_q, be_d;
    logic              rw_q, rw_d;
    logic              oe_q, oe_d;
    logic              as_q, as_d;
    logic              uds_q, uds_d;
    logic              lds_q, lds_d;

    // Address is word aligned: the byte select comes from the enables instead
    logic unused_addr_lsb;
    assign unused_addr_lsb = ReqAddr[0];

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             berr_q, berr_d;
`endif

    // Next-state and bus-output computation for the transfer sequencer
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        as_d    = as_q;
        uds_d   = uds_q;
        lds_d   = lds_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
        berr_d  = berr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Req_H) begin
                    state_d = ST_ADDR;
                    addr_d  = {ReqAddr[ADDR_W-1:1], 1'b0};
                    wdata_d = ReqWrData;
                    be_d    = be_normalize(ReqByteEn);
                    rw_d    = ReqRW_H;
                    oe_d    = ~ReqRW_H;
`ifdef BUS_TIMEOUT_EN
                    berr_d  = 1'b0;
`endif
                end
            end
            ST_ADDR: begin
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                state_d = ST_WAIT_DTACK;
                as_d    = 1'b0;
                uds_d   = ~be_q[1];
                lds_d   = ~be_q[0];
`ifdef BUS_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT_DTACK: begin
                if (!dtack_q) begin
                    state_d = ST_LATCH;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    // Nobody answered: abandon the cycle and flag a bus error
                    state_d = ST_RELEASE;
                    as_d    = 1'b1;
                    uds_d   = 1'b1;
                    lds_d   = 1'b1;
                    oe_d    = 1'b0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            ST_LATCH: begin
                if (rw_q) begin
                    rdata_d = DataIn;
                end
                state_d = ST_RELEASE;
                as_d    = 1'b1;
                uds_d   = 1'b1;
                lds_d   = 1'b1;
                oe_d    = 1'b0;
            end
            ST_RELEASE: begin
                // Wait for the responder to withdraw DTACK before finishing
                if (dtack_q) begin
                    state_d = ST_IDLE;
                    rw_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bus-output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            state_q <= ST_IDLE;
            dtack_q <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= BE_BOTH;
            rw_q    <= 1'b1;
            oe_q    <= 1'b0;
            as_q    <= 1'b1;
            uds_q   <= 1'b1;
            lds_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            dtack_q <= DtackIn_L;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            as_q    <= as_d;
            uds_q   <= uds_d;
            lds_q   <= lds_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    // Timeout counter and bus-error flag
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            cnt_q  <= '0;
            berr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            berr_q <= berr_d;
        end
    end
    assign Berr_H = Done_H & berr_q;
`else
    assign Berr_H = 1'b0;
`endif

    assign Busy_H      = (state_q != ST_IDLE);
    assign Done_H      = (state_q == ST_RELEASE) && dtack_q;
    assign RdData      = rdata_q;
    assign AddressOut  = addr_q;
    assign DataOut     = wdata_q;
    assign DataOutEn_H = oe_q;
    assign RW_L        = rw_q;
    assign AS_L        = as_q;
    assign UDS_L       = uds_q;
    assign LDS_L       = lds_q;

endmodule

`default_nettype wire

// File: tb/tb_m68k_bus_initiator.sv
// ============================================================================
//  Module      : tb_m68k_bus_initiator
//  Description : Self-checking bench for m68k_bus_initiator. A behavioural
//                DTACK responder (programmable assert delay and hold time)
//                answers the bus; expected timing and data come from the
//                transfer-level rules (AS_L low 2 cycles after accept, Done_H
//                6 + delay + hold cycles after accept).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m68k_bus_initiator;

    localparam int AW = 32;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          Clock = 1'b0;
    logic          Reset_H = 1'b1;
    logic          Req_H = 1'b0;
    logic          ReqRW_H = 1'b1;
    logic [AW-1:0] ReqAddr = '0;
    logic [1:0]    ReqByteEn = 2'b00;
    logic [DW-1:0] ReqWrData = '0;
    logic [DW-1:0] DataIn = '0;
    logic          Busy_H, Done_H, Berr_H;
    logic [DW-1:0] RdData, DataOut;
    logic [AW-1:0] AddressOut;
    logic          DataOutEn_H, RW_L, AS_L, UDS_L, LDS_L;
    logic          DtackIn_L;

    int n_checks = 0;
    int n_fail   = 0;

    // Responder configuration and state
    int rsp_delay = 0;
    int rsp_hold  = 0;
    int low_cnt   = 0;
    int hold_rem  = 0;

    // Reference model state: last read data delivered to the client
    logic [DW-1:0] exp_rd = '0;

    always #5 Clock = ~Clock;

`ifdef BUS_TIMEOUT_EN
    m68k_bus_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
`else
    m68k_bus_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
`endif
        .Clock(Clock), .Reset_H(Reset_H),
        .Req_H(Req_H), .ReqRW_H(ReqRW_H), .ReqAddr(ReqAddr),
        .ReqByteEn(ReqByteEn), .ReqWrData(ReqWrData),
        .Busy_H(Busy_H), .Done_H(Done_H), .Berr_H(Berr_H), .RdData(RdData),
        .AddressOut(AddressOut), .DataOut(DataOut), .DataOutEn_H(DataOutEn_H),
        .RW_L(RW_L), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
        .DataIn(DataIn), .DtackIn_L(DtackIn_L)
    );

    // Responder: DTACK asserts rsp_delay cycles after AS_L falls (0 = same
    // cycle), and stays asserted rsp_hold cycles after AS_L rises.
    assign DtackIn_L = !(((AS_L === 1'b0) && (low_cnt >= rsp_delay)) ||
                         ((AS_L === 1'b1) && (hold_rem > 0)));

    always @(posedge Clock) begin
        if (AS_L === 1'b0) begin
            low_cnt  <= low_cnt + 1;
            hold_rem <= (low_cnt >= rsp_delay) ? rsp_hold : 0;
        end else begin
            low_cnt  <= 0;
            if (hold_rem > 0) hold_rem <= hold_rem - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transfer; entered and left just after a falling edge
    task automatic run_xfer(input logic rw, input logic [AW-1:0] addr,
                            input logic [1:0] be, input logic [DW-1:0] wd,
                            input logic [DW-1:0] rd, input int d, input int h,
                            input bit hold_req, input bit exp_berr);
        logic [1:0] be_eff;
        int exp_done, n, first_low, done_n;
        be_eff   = (be == 2'b00) ? 2'b11 : be;
        exp_done = exp_berr ? (2 + TO) : (6 + d + h);
        rsp_delay = d;
        rsp_hold  = h;
        Req_H = 1'b1; ReqRW_H = rw; ReqAddr = addr; ReqByteEn = be;
        ReqWrData = wd; DataIn = rd;
        @(posedge Clock);
        @(negedge Clock);
        check("busy_accept", {31'd0, Busy_H}, 32'd1);
        check("as_addr_phase", {31'd0, AS_L}, 32'd1);
        if (!hold_req) Req_H = 1'b0;
        n = 0; first_low = -1; done_n = -1;
        while (done_n < 0 && n < exp_done + 20) begin
            @(posedge Clock);
            @(negedge Clock);
            n++;
            if (AS_L === 1'b0 && first_low < 0) begin
                first_low = n;
                check("uds", {31'd0, UDS_L}, {31'd0, ~be_eff[1]});
                check("lds", {31'd0, LDS_L}, {31'd0, ~be_eff[0]});
                check("rw", {31'd0, RW_L}, {31'd0, rw});
                check("oe", {31'd0, DataOutEn_H}, {31'd0, ~rw});
                check("addr", AddressOut, {addr[AW-1:1], 1'b0});
                if (!rw) check("wdata", {16'd0, DataOut}, {16'd0, wd});
            end
            if (Done_H === 1'b1) done_n = n;
        end
        check("as_fall_cycle", first_low, 2);
        check("done_cycle", done_n, exp_done);
        if (done_n >= 0) begin
            if (rw && !exp_berr) exp_rd = rd;
            check("berr", {31'd0, Berr_H}, {31'd0, exp_berr});
            check("rdata", {16'd0, RdData}, {16'd0, exp_rd});
            check("as_at_done", {31'd0, AS_L}, 32'd1);
            @(posedge Clock);
            @(negedge Clock);
            check("done_pulse_len", {31'd0, Done_H}, 32'd0);
            check("busy_after_done", {31'd0, Busy_H}, 32'd0);
            check("as_between", {31'd0, AS_L}, 32'd1);
        end
    endtask

    initial begin
        int done_seen;
        // Reset state
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_as", {31'd0, AS_L}, 32'd1);
        check("rst_uds", {31'd0, UDS_L}, 32'd1);
        check("rst_lds", {31'd0, LDS_L}, 32'd1);
        check("rst_rw", {31'd0, RW_L}, 32'd1);
        check("rst_oe", {31'd0, DataOutEn_H}, 32'd0);
        check("rst_busy", {31'd0, Busy_H}, 32'd0);
        check("rst_done", {31'd0, Done_H}, 32'd0);
        check("rst_berr", {31'd0, Berr_H}, 32'd0);
        check("rst_addr", AddressOut, 32'd0);
        check("rst_dout", {16'd0, DataOut}, 32'd0);
        check("rst_rdata", {16'd0, RdData}, 32'd0);
        Reset_H = 1'b0;

        // Zero-wait read
        run_xfer(1'b1, 32'h00F0_0010, 2'b11, 16'h0000, 16'hBEEF, 0, 0, 1'b0, 1'b0);
        // Delayed write, upper byte only (RdData must stay BEEF)
        run_xfer(1'b0, 32'h0000_4000, 2'b10, 16'h12AB, 16'h5555, 10, 0, 1'b0, 1'b0);
        // DTACK held 3 cycles after AS_L negates
        run_xfer(1'b1, 32'h0000_0102, 2'b01, 16'h0000, 16'hC0DE, 0, 3, 1'b0, 1'b0);
        // Byte enable 00 behaves as 11, odd address bit dropped
        run_xfer(1'b1, 32'h1234_5677, 2'b00, 16'h0000, 16'hA5A5, 2, 1, 1'b0, 1'b0);

        // Stuck DTACK
`ifdef BUS_TIMEOUT_EN
        run_xfer(1'b1, 32'h0000_0200, 2'b11, 16'h0000, 16'hDEAD, 1000000, 0, 1'b0, 1'b1);
`else
        rsp_delay = 1000000; rsp_hold = 0;
        Req_H = 1'b1; ReqRW_H = 1'b1; ReqAddr = 32'h0000_0200; ReqByteEn = 2'b11;
        @(posedge Clock);
        @(negedge Clock);
        Req_H = 1'b0;
        done_seen = 0;
        repeat (1000) begin
            @(posedge Clock);
            @(negedge Clock);
            if (Done_H === 1'b1) done_seen++;
        end
        check("stuck_busy", {31'd0, Busy_H}, 32'd1);
        check("stuck_as", {31'd0, AS_L}, 32'd0);
        check("stuck_no_done", done_seen, 0);
        Reset_H = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset_H = 1'b0;
        exp_rd = '0;
`endif

        // Reset pulsed while waiting for DTACK
        rsp_delay = 50; rsp_hold = 0;
        Req_H = 1'b1; ReqRW_H = 1'b1; ReqAddr = 32'h0000_0300; ReqByteEn = 2'b11;
        @(posedge Clock);
        @(negedge Clock);
        Req_H = 1'b0;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("pre_rst_as", {31'd0, AS_L}, 32'd0);
        Reset_H = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset_H = 1'b0;
        exp_rd = '0;
        check("abort_as", {31'd0, AS_L}, 32'd1);
        check("abort_uds", {31'd0, UDS_L}, 32'd1);
        check("abort_lds", {31'd0, LDS_L}, 32'd1);
        check("abort_busy", {31'd0, Busy_H}, 32'd0);
        check("abort_done", {31'd0, Done_H}, 32'd0);
        check("abort_rdata", {16'd0, RdData}, 32'd0);
        run_xfer(1'b1, 32'h0000_0400, 2'b11, 16'h0000, 16'h1357, 1, 0, 1'b0, 1'b0);

        // Req_H held across two transfers
        run_xfer(1'b1, 32'h0000_0500, 2'b11, 16'h0000, 16'h2468, 0, 0, 1'b1, 1'b0);
        run_xfer(1'b0, 32'h0000_0502, 2'b01, 16'h00FF, 16'h0000, 0, 0, 1'b0, 1'b0);

        // Randomized transfers
        for (int i = 0; i < 12; i++) begin
            logic          r_rw;
            logic [AW-1:0] r_addr;
            logic [1:0]    r_be;
            logic [DW-1:0] r_wd, r_rd;
            r_rw   = 1'($urandom_range(0, 1));
            r_addr = $urandom;
            r_be   = 2'($urandom_range(0, 3));
            r_wd   = 16'($urandom);
            r_rd   = 16'($urandom);
            run_xfer(r_rw, r_addr, r_be, r_wd, r_rd,
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
